// File: rtl/fetch_unit.sv
// fetch_unit: samples the PC, runs a req/ack program-memory read, and latches the result into the instruction register.
// Optional FETCH_TIMEOUT_EN bounds WAIT and substitutes NOP_INSTR with a sticky fetch_err.
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int INSTR_W = 8,
  parameter int TIMEOUT = 15,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 8'h00
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               stall,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_ack,
  input  logic               exec_done,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic               phase,
  output logic               incPC,
  output logic               fetch_err
);
  typedef enum logic [1:0] {FETCH, WAIT, EXEC} state_t;
  state_t state, nxt;
  logic timeout, load;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign timeout = state == WAIT && !mem_ack && cnt == CW'(TIMEOUT);
  // Held at zero outside WAIT, so every new request starts counting from zero.
  always_ff @(posedge clk)
    if (Rst || state != WAIT) cnt <= '0;
    else if (!mem_ack) cnt <= cnt + 1'b1;
  always_ff @(posedge clk)
    if (Rst) fetch_err <= 1'b0;
    else if (timeout) fetch_err <= 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= Rst ? FETCH : nxt;
  always_comb begin
    nxt = state == FETCH ? (stall ? FETCH : WAIT)
        : state == WAIT  ? (mem_ack || timeout ? EXEC : WAIT)
        : (exec_done ? FETCH : EXEC);
    load = state == WAIT && nxt == EXEC;
  end
  always_ff @(posedge clk)
    if (Rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      instr    <= '0;
      phase    <= 1'b0;
      incPC    <= 1'b0;
    end else begin
      mem_req <= nxt == WAIT;
      if (state == FETCH && !stall) mem_addr <= addr;
      if (load) instr <= timeout ? NOP_INSTR : mem_data;
      incPC <= load;
      phase <= nxt == EXEC;
    end
  assign opcode  = instr[INSTR_W-1 -: 4];
  assign operand = instr[3:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle vectors plus hand sequences for delayed ack and (if enabled) timeout.
module tb_fetch_unit;
  logic clk = 0, Rst = 1, stall = 0, mem_ack = 0, exec_done = 0;
  logic [11:0] addr = '0;
  logic [7:0] mem_data = '0;
  logic mem_req, phase, incPC, fetch_err;
  logic [11:0] mem_addr;
  logic [7:0] instr;
  logic [3:0] opcode, operand;
  int tests = 0, fails = 0;

  fetch_unit dut (
    .clk(clk), .Rst(Rst), .addr(addr), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .exec_done(exec_done), .instr(instr), .opcode(opcode),
    .operand(operand), .phase(phase), .incPC(incPC), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, a, d;
    logic [11:0] ad;
    logic [7:0] dt;
    logic e_req;
    logic [11:0] e_addr;
    logic [7:0] e_instr;
    logic e_phase, e_inc;
  } vec_t;
  vec_t v[17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic a, input logic d,
                      input logic [11:0] ad, input logic [7:0] dt);
    Rst = r; stall = s; mem_ack = a; exec_done = d; addr = ad; mem_data = dt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = '{1,0,1,0,12'h359,8'hA7, 0,12'h000,8'h00,0,0};
    v[1]  = '{1,0,1,0,12'h359,8'hA7, 0,12'h000,8'h00,0,0};
    v[2]  = '{0,0,1,0,12'h359,8'hA7, 1,12'h359,8'h00,0,0};
    v[3]  = '{0,0,1,0,12'h35A,8'hA7, 0,12'h359,8'hA7,1,1};
    v[4]  = '{0,0,0,0,12'h35A,8'h11, 0,12'h359,8'hA7,1,0};
    v[5]  = '{0,0,0,1,12'h35A,8'h11, 0,12'h359,8'hA7,0,0};
    v[6]  = '{0,1,0,0,12'h35A,8'h11, 0,12'h359,8'hA7,0,0};
    v[7]  = '{0,1,0,1,12'h35A,8'h11, 0,12'h359,8'hA7,0,0};
    v[8]  = '{0,1,0,0,12'h35A,8'h11, 0,12'h359,8'hA7,0,0};
    v[9]  = '{0,1,1,1,12'h35A,8'h11, 0,12'h359,8'hA7,0,0};
    v[10] = '{0,0,0,0,12'h35A,8'h11, 1,12'h35A,8'hA7,0,0};
    v[11] = '{0,1,0,1,12'h400,8'h11, 1,12'h35A,8'hA7,0,0};
    v[12] = '{0,0,1,0,12'h400,8'h3C, 0,12'h35A,8'h3C,1,1};
    v[13] = '{0,0,0,1,12'h35B,8'h00, 0,12'h35A,8'h3C,0,0};
    v[14] = '{0,0,0,0,12'h100,8'h00, 1,12'h100,8'h3C,0,0};
    v[15] = '{1,0,0,0,12'h100,8'h00, 0,12'h000,8'h00,0,0};
    v[16] = '{0,1,1,0,12'h100,8'hFF, 0,12'h000,8'h00,0,0};
    #2;
    for (int i = 0; i < 17; i++) begin
      step(v[i].r, v[i].s, v[i].a, v[i].d, v[i].ad, v[i].dt);
      check($sformatf("v%0d.mem_req", i), 16'(mem_req), 16'(v[i].e_req));
      check($sformatf("v%0d.mem_addr", i), 16'(mem_addr), 16'(v[i].e_addr));
      check($sformatf("v%0d.instr", i), 16'(instr), 16'(v[i].e_instr));
      check($sformatf("v%0d.opcode", i), 16'(opcode), 16'(v[i].e_instr[7:4]));
      check($sformatf("v%0d.operand", i), 16'(operand), 16'(v[i].e_instr[3:0]));
      check($sformatf("v%0d.phase", i), 16'(phase), 16'(v[i].e_phase));
      check($sformatf("v%0d.incPC", i), 16'(incPC), 16'(v[i].e_inc));
      check($sformatf("v%0d.fetch_err", i), 16'(fetch_err), 16'h0);
    end
    // Ack delayed five cycles: request held steady, one incPC pulse.
    step(0,0,0,0,12'h2A4,8'h00);
    check("dly.req", 16'(mem_req), 16'h1);
    check("dly.addr", 16'(mem_addr), 16'h2A4);
    for (int k = 0; k < 5; k++) begin
      step(0,0,0,1,12'h2A5,8'h90 + 8'(k));
      check($sformatf("dly%0d.req", k), 16'(mem_req), 16'h1);
      check($sformatf("dly%0d.addr", k), 16'(mem_addr), 16'h2A4);
      check($sformatf("dly%0d.instr", k), 16'(instr), 16'h00);
      check($sformatf("dly%0d.inc", k), 16'(incPC), 16'h0);
    end
    step(0,0,1,0,12'h2A5,8'h5E);
    check("dly.instr", 16'(instr), 16'h5E);
    check("dly.inc", 16'(incPC), 16'h1);
    check("dly.phase", 16'(phase), 16'h1);
    check("dly.req_low", 16'(mem_req), 16'h0);
    step(0,0,1,0,12'h2A5,8'h77);
    check("dly.inc_once", 16'(incPC), 16'h0);
    check("dly.instr_hold", 16'(instr), 16'h5E);
    step(0,0,0,1,12'h2A5,8'h00);
    check("dly.back_fetch", 16'(phase), 16'h0);
`ifdef FETCH_TIMEOUT_EN
    begin
      int n = 0;
      step(0,0,0,0,12'h300,8'h99);
      while (!incPC && n < 40) begin
        step(0,0,0,0,12'h300,8'h99);
        n++;
      end
      check("to.cycles", 16'(n), 16'd16);
      check("to.instr", 16'(instr), 16'h00);
      check("to.err", 16'(fetch_err), 16'h1);
      check("to.phase", 16'(phase), 16'h1);
      step(0,0,0,1,12'h301,8'h00);
      step(0,0,0,0,12'h301,8'h00);
      step(0,0,1,0,12'h301,8'h42);
      check("to.sticky_instr", 16'(instr), 16'h42);
      check("to.sticky_err", 16'(fetch_err), 16'h1);
      step(1,0,0,0,12'h000,8'h00);
      check("to.rst_err", 16'(fetch_err), 16'h0);
      step(0,0,0,0,12'h310,8'h00);
      for (int k = 0; k < 15; k++) step(0,0,0,0,12'h310,8'h00);
      check("to.edge_req", 16'(mem_req), 16'h1);
      step(0,0,1,0,12'h310,8'h6B);
      check("to.edge_instr", 16'(instr), 16'h6B);
      check("to.edge_inc", 16'(incPC), 16'h1);
      check("to.edge_err", 16'(fetch_err), 16'h0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
